// File: rtl/demux1x4_sched.sv
// Round-robin dispatcher in front of a 1x4 demux: holds one word and
// offers it to exactly one enabled channel, rotating among channels.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   e, chan_en       global enable, per-channel eligibility mask
//   in_valid/ready   input stream handshake, in_data input word
//   out_valid[4]     one-hot offer, out_ready[4] per-channel accept
//   out_data         held word (shared bus), sel demux select
//   busy             word held, cnt delivered-word count (wraps)
module demux1x4_sched #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          e,
  input  logic [3:0]    chan_en,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic [3:0]    out_valid,
  input  logic [3:0]    out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    sel,
  output logic          busy,
  output logic [7:0]    cnt
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    sel_q, sel_d;
  logic [DW-1:0] data_q, data_d;
  logic [7:0]    cnt_q, cnt_d;

  logic       deliver;
  logic       accept;
  logic [1:0] base;

  // First enabled channel starting at p, wrapping 3 -> 0.
  // An empty mask never reaches here since in_ready is then low.
  function automatic logic [1:0] tgt(
    input logic [1:0] p,
    input logic [3:0] m
  );
    logic [1:0] k;
    logic [1:0] r;
    logic       hit;
    r   = p;
    hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      k = p + 2'(i);
      if (!hit && m[k]) begin
        r   = k;
        hit = 1'b1;
      end
    end
    return r;
  endfunction

  assign deliver = (state_q == HOLD) && out_ready[sel_q];

  // deliver feeds in_ready combinationally so a ready channel
  // sustains one word per cycle.
  assign in_ready = e && (chan_en != 4'b0000)
                  && ((state_q == IDLE) || deliver);

  assign accept = in_valid && in_ready;

  // After a delivery in the same cycle, rotation continues past the
  // channel just served rather than the stale pointer.
  assign base = deliver ? (sel_q + 2'd1) : ptr_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    cnt_d   = cnt_q;

    if (deliver) begin
      ptr_d = sel_q + 2'd1;
      cnt_d = cnt_q + 8'd1;
    end

    if (accept) begin
      data_d = in_data;
      sel_d  = tgt(base, chan_en);
    end

    unique case (state_q)
      IDLE: begin
        if (accept) state_d = HOLD;
      end
      HOLD: begin
        if (deliver && !accept) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      data_q  <= '0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = (state_q == HOLD) ? (4'b0001 << sel_q) : 4'b0000;
  assign out_data  = data_q;
  assign sel       = sel_q;
  assign busy      = (state_q == HOLD);
  assign cnt       = cnt_q;

endmodule

// File: tb/tb_demux1x4_sched.sv
// Directed bench for demux1x4_sched: rotation, masking, stalls,
// enable gating, reset during hold and count wrap.
module tb_demux1x4_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       e;
  logic [3:0] chan_en;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] out_data;
  logic [1:0] sel;
  logic       busy;
  logic [7:0] cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  demux1x4_sched #(.DW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .e         (e),
    .chan_en   (chan_en),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sel       (sel),
    .busy      (busy),
    .cnt       (cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; e = 1'b1; chan_en = 4'b1111;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 4'b1111;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 4'b0000) begin
      $display("FAIL rst_out_valid got %b want 0000", out_valid); n_fail++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      $display("FAIL rst_busy got %b want 0", busy); n_fail++;
    end
    n_cmp++;
    if (cnt !== 8'd0 || sel !== 2'd0 || out_data !== 8'h00) begin
      $display("FAIL rst_regs got cnt=%0d sel=%0d data=%h want 0 0 00",
               cnt, sel, out_data);
      n_fail++;
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      $display("FAIL rst_in_ready got %b want 1", in_ready); n_fail++;
    end
  endtask

  task automatic test_rr_all();
    logic [3:0] exp_v;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hA0 + 8'(i);
      tick();
      exp_v = 4'b0001 << (i % 4);
      n_cmp++;
      if (out_valid !== exp_v || out_data !== 8'hA0 + 8'(i)
          || cnt !== 8'(i)) begin
        $display("FAIL rr_word%0d got v=%b d=%h c=%0d want v=%b d=%h c=%0d",
                 i, out_valid, out_data, cnt, exp_v, 8'hA0 + 8'(i), i);
        n_fail++;
      end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++;
    if (cnt !== 8'd8 || busy !== 1'b0 || out_valid !== 4'b0000) begin
      $display("FAIL rr_drain got cnt=%0d busy=%b v=%b want 8 0 0000",
               cnt, busy, out_valid);
      n_fail++;
    end
  endtask

  task automatic test_mask();
    logic [3:0] exp_v [4];
    exp_v[0] = 4'b0001; exp_v[1] = 4'b0100;
    exp_v[2] = 4'b0001; exp_v[3] = 4'b0100;
    chan_en = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hB0 + 8'(i);
      tick();
      n_cmp++;
      if (out_valid !== exp_v[i] || out_data !== 8'hB0 + 8'(i)) begin
        $display("FAIL mask_word%0d got v=%b d=%h want v=%b d=%h",
                 i, out_valid, out_data, exp_v[i], 8'hB0 + 8'(i));
        n_fail++;
      end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++;
    if (cnt !== 8'd12 || busy !== 1'b0) begin
      $display("FAIL mask_drain got cnt=%0d busy=%b want 12 0", cnt, busy);
      n_fail++;
    end
  endtask

  task automatic test_stall();
    // ptr is 3 here; a one-channel mask forces the word onto channel 1.
    chan_en   = 4'b0010;
    out_ready = 4'b1101;
    in_valid  = 1'b1;
    in_data   = 8'hC0;
    tick();
    chan_en = 4'b1111;
    in_data = 8'hC1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++;
      if (out_data !== 8'hC0 || out_valid !== 4'b0010 || busy !== 1'b1
          || in_ready !== 1'b0) begin
        $display("FAIL stall_c%0d got d=%h v=%b b=%b r=%b want c0 0010 1 0",
                 c, out_data, out_valid, busy, in_ready);
        n_fail++;
      end
      tick();
    end
    out_ready = 4'b1111;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      $display("FAIL stall_release_ready got %b want 1", in_ready); n_fail++;
    end
    tick();
    n_cmp++;
    if (out_valid !== 4'b0100 || out_data !== 8'hC1 || cnt !== 8'd13) begin
      $display("FAIL stall_next got v=%b d=%h c=%0d want 0100 c1 13",
               out_valid, out_data, cnt);
      n_fail++;
    end
    in_valid = 1'b0;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || cnt !== 8'd14) begin
      $display("FAIL stall_drain got busy=%b cnt=%0d want 0 14", busy, cnt);
      n_fail++;
    end
  endtask

  task automatic test_mask_change();
    chan_en   = 4'b0010;
    out_ready = 4'b0000;
    in_valid  = 1'b1;
    in_data   = 8'hD0;
    tick();
    in_valid = 1'b0;
    chan_en  = 4'b1000;
    tick();
    n_cmp++;
    if (out_valid !== 4'b0010 || out_data !== 8'hD0) begin
      $display("FAIL mchg_hold got v=%b d=%h want 0010 d0",
               out_valid, out_data);
      n_fail++;
    end
    out_ready = 4'b0010;
    in_valid  = 1'b1;
    in_data   = 8'hD1;
    tick();
    n_cmp++;
    if (out_valid !== 4'b1000 || sel !== 2'd3 || out_data !== 8'hD1
        || cnt !== 8'd15) begin
      $display("FAIL mchg_next got v=%b s=%0d d=%h c=%0d want 1000 3 d1 15",
               out_valid, sel, out_data, cnt);
      n_fail++;
    end
    in_valid  = 1'b0;
    out_ready = 4'b1111;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || cnt !== 8'd16) begin
      $display("FAIL mchg_drain got busy=%b cnt=%0d want 0 16", busy, cnt);
      n_fail++;
    end
  endtask

  task automatic test_gating();
    e = 1'b0; chan_en = 4'b1111; in_valid = 1'b1; in_data = 8'hE0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      $display("FAIL gate_e0_ready got %b want 0", in_ready); n_fail++;
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      $display("FAIL gate_e0_busy got %b want 0", busy); n_fail++;
    end
    e = 1'b1; chan_en = 4'b0000;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      $display("FAIL gate_mask0_ready got %b want 0", in_ready); n_fail++;
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0 || cnt !== 8'd16) begin
      $display("FAIL gate_mask0_state got busy=%b cnt=%0d want 0 16",
               busy, cnt);
      n_fail++;
    end
    chan_en = 4'b0010;
    in_data = 8'hE1;
    tick();
    n_cmp++;
    if (out_valid !== 4'b0010 || out_data !== 8'hE1) begin
      $display("FAIL gate_restore got v=%b d=%h want 0010 e1",
               out_valid, out_data);
      n_fail++;
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_hold_wrap();
    rst = 1'b1;
    tick();
    rst = 1'b0; chan_en = 4'b1111; out_ready = 4'b1111;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'h10 + 8'(i);
      tick();
    end
    // word 4 sits on channel 0; deliver it and steer word 5 to channel 2
    chan_en = 4'b0100;
    in_data = 8'h15;
    tick();
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    chan_en   = 4'b1111;
    tick();
    n_cmp++;
    if (sel !== 2'd2 || cnt !== 8'd5 || busy !== 1'b1) begin
      $display("FAIL rh_setup got sel=%0d cnt=%0d busy=%b want 2 5 1",
               sel, cnt, busy);
      n_fail++;
    end
    rst = 1'b1; out_ready = 4'b1111; in_valid = 1'b1; in_data = 8'h77;
    tick();
    n_cmp++;
    if (out_valid !== 4'b0000 || busy !== 1'b0 || cnt !== 8'd0
        || sel !== 2'd0 || out_data !== 8'h00) begin
      $display("FAIL rh_reset got v=%b b=%b c=%0d s=%0d d=%h want 0 0 0 0 00",
               out_valid, busy, cnt, sel, out_data);
      n_fail++;
    end
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      in_data = 8'(i);
      tick();
    end
    n_cmp++;
    if (cnt !== 8'd255) begin
      $display("FAIL wrap_pre got %0d want 255", cnt); n_fail++;
    end
    in_valid = 1'b0;
    tick();
    n_cmp++;
    if (cnt !== 8'd0 || busy !== 1'b0) begin
      $display("FAIL wrap_zero got cnt=%0d busy=%b want 0 0", cnt, busy);
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_rr_all();
    test_mask();
    test_stall();
    test_mask_change();
    test_gating();
    test_reset_hold_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/demux1x4_sched.md
# demux1x4_sched

Round-robin dispatcher that feeds a 1-to-4 demultiplexed datapath from a single valid/ready input stream. Each accepted word is held in an output register and steered to exactly one of four output channels, chosen in rotation among the enabled channels. A per-word handshake on each channel guarantees no word is dropped or duplicated. The block sits in front of the 1x4 demux, drives its select and enable, and owns the channel-sharing policy.

## Interface
Parameters:
- DW, 8, data width of the input and output words.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- e  in  1  global enable; 0 blocks new acceptance.
- chan_en  in  4  per-channel enable mask; bit k = channel k eligible.
- in_valid  in  1  input word present.
- in_data  in  DW  input word.
- in_ready  out  1  block accepts in_data this cycle.
- out_valid  out  4  one-hot; bit k = held word offered to channel k.
- out_ready  in  4  channel k accepts its offered word.
- out_data  out  DW  held word; common bus to all channels.
- sel  out  2  channel currently targeted (demux select).
- busy  out  1  a word is held.
- cnt  out  8  delivered-word count, wraps 255 -> 0.

## Operation
- State machine with 2 states:
  - IDLE: no word held.
  - HOLD: word held in out_data, offered on out_valid[sel].
- ptr (2 bits) is the rotation pointer.
- tgt(p) is the first k in the order p, p+1, p+2, p+3 (mod 4) with chan_en[k]=1. It is undefined when chan_en=0.
- deliver = HOLD & out_ready[sel].
- in_ready = e & (chan_en != 0) & (IDLE | deliver). The deliver term is a combinational path from out_ready to in_ready, by design.
- accept = in_valid & in_ready.
- On accept:
  - out_data <= in_data.
  - sel <= tgt(base), where base = sel+1 if deliver is true in the same cycle, else ptr.
  - State <= HOLD.
- On deliver:
  - ptr <= sel+1 (mod 4).
  - cnt <= cnt+1.
  - State <= IDLE, unless accept occurs in the same cycle, in which case state stays HOLD with the new word.
- out_valid = HOLD ? (1 << sel) : 0.
- busy = HOLD.
- chan_en or e changing during HOLD does not retarget, cancel or drop the held word; it is still delivered to sel. The mask only affects the next tgt computation.
- chan_en = 0 or e = 0: in_ready=0; any held word still completes.
- out_ready bits for channels other than sel are ignored.

## Timing
- Reset values:
  - State IDLE, ptr=0, sel=0, out_data=0, out_valid=0, busy=0, cnt=0.
  - in_ready follows its equation, so it is 1 immediately after reset if e=1 and chan_en!=0.
- Reset has priority over accept and deliver in the same cycle. A held word is discarded on reset, and cnt is not incremented.
- Latency: a word accepted at edge N appears on out_valid/out_data after edge N. It is delivered at the first edge M>N with out_ready[sel]=1.
- Throughput is 1 word/cycle when the targeted channel is always ready (accept and deliver in the same cycle).
- Wrap-around:
  - sel=3 delivered sets ptr=0.
  - tgt search wraps 3 -> 0.
  - cnt 255 -> 0 on the next delivery.
- A single enabled channel k makes every word go to k.

## Test plan
- Reset, e=1, chan_en=1111, all out_ready=1, 8 words in_valid continuous (A0..A7) -> one word/cycle on channels 0,1,2,3,0,1,2,3; cnt=8; out_valid never multi-hot.
- chan_en=0101, 4 words, all ready -> channels 0,2,0,2; channels 1 and 3 never see out_valid.
- Word to channel 1 with out_ready[1]=0 for 5 cycles and in_valid held -> out_data stable, out_valid=0010, busy=1, in_ready=0 for 5 cycles; delivered on cycle 6 with the next word accepted the same cycle, targeted at channel 2.
- Change chan_en from 1111 to 1000 while a word is held for channel 1 -> word delivered on channel 1; next word goes to channel 3.
- e=0 or chan_en=0000 with in_valid=1 -> in_ready=0, nothing accepted; restoring e=1 with chan_en=0010 -> next word goes to channel 1.
- Assert rst during HOLD (sel=2, cnt=5) -> next cycle all outputs at reset values, cnt=0, out_valid=0; 256 further deliveries -> cnt wraps to 0.
